// File: rtl/vmg_job_sequencer_pkg.sv
// Shared types and sizes for the vector-multiplier job sequencer.
package vmg_pkg;

  localparam int Q            = 4;   // parallel multiplier lanes
  localparam int NP           = 4;   // elements per lane per beat
  localparam int REG_DEPTH    = 8;   // element width
  localparam int DEF_PIPE_LAT = 3;   // default array latency, ce beat -> acc/ai
  localparam int LEN_W        = 16;  // job length field width
  localparam int ACC_W        = 32;  // per-lane accumulator width

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } state_t;

  // Operand register control: keep, take the incoming beat, or flush with zeros.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_ZERO
  } op_ctl_t;

  typedef logic [NP-1:0][REG_DEPTH-1:0]        lane_op_t;
  typedef logic [Q-1:0][NP-1:0][REG_DEPTH-1:0] operand_t;
  typedef logic [Q-1:0][ACC_W-1:0]             lane_acc_t;
  typedef logic [LEN_W-1:0]                    len_t;

endpackage

// File: rtl/vmg_job_sequencer_if.sv
// Job, operand-stream, array and result signals of the sequencer.
// master = sequencer side, slave = fetch logic / array / result consumer.
interface vmg_job_sequencer_if;
  import vmg_pkg::*;

  logic      start;
  len_t      len;
  logic      busy;
  logic      in_valid;
  logic      in_ready;
  operand_t  features_in;
  operand_t  weights_in;
  logic      mult_clr;
  logic      mult_ce;
  operand_t  mult_features;
  operand_t  mult_weights;
  lane_acc_t acc_in;
  lane_acc_t ai_in;
  logic      res_valid;
  logic      res_ready;
  lane_acc_t res_acc;
  lane_acc_t res_ai;
  logic      done;

  modport master (
    input  start, len, in_valid, features_in, weights_in, acc_in, ai_in, res_ready,
    output busy, in_ready, mult_clr, mult_ce, mult_features, mult_weights,
           res_valid, res_acc, res_ai, done
  );

  modport slave (
    output start, len, in_valid, features_in, weights_in, acc_in, ai_in, res_ready,
    input  busy, in_ready, mult_clr, mult_ce, mult_features, mult_weights,
           res_valid, res_acc, res_ai, done
  );

endinterface

// File: rtl/vmg_job_sequencer_operand_stage.sv
// Operand register in front of the multiplier array. Loads a beat, forces
// zeros for the flush, or holds; ce follows one cycle after any load/zero.
module vmg_operand_stage
  import vmg_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  op_ctl_t  ctl,
  input  operand_t feat_d,
  input  operand_t wgt_d,
  output operand_t feat_q,
  output operand_t wgt_q,
  output logic     ce
);

  for (genvar l = 0; l < Q; l++) begin : g_lane
    // Per-lane operand register with load/zero/hold select
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        feat_q[l] <= '0;
        wgt_q[l]  <= '0;
      end else begin
        case (ctl)
          OP_LOAD: begin
            feat_q[l] <= feat_d[l];
            wgt_q[l]  <= wgt_d[l];
          end
          OP_ZERO: begin
            feat_q[l] <= '0;
            wgt_q[l]  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // ce marks the cycle in which the register holds a fresh (or zero) operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ce <= 1'b0;
    else     ce <= (ctl == OP_LOAD) || (ctl == OP_ZERO);
  end

endmodule

// File: rtl/vmg_job_sequencer.sv
// Sequences one dot-product job: clear the array, stream LEN beats, flush
// the pipeline with zero operands, then hold the captured acc/ai until taken.
module vmg_job_sequencer
  import vmg_pkg::*;
#(
  parameter int PIPE_LAT = DEF_PIPE_LAT
)(
  input logic                 clk,
  input logic                 rst,
  vmg_job_sequencer_if.master bus
);

  localparam int DW = $clog2(PIPE_LAT + 2);

  state_t          state, nxt;
  op_ctl_t         op_ctl;
  len_t            len_q, beat_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            in_ready, accept, last_beat, drain_last, res_take;
  logic            res_valid_q;
  lane_acc_t       res_acc_q, res_ai_q;

  assign in_ready   = (state == STREAM);
  assign accept     = in_ready & bus.in_valid;
  assign last_beat  = accept && (beat_cnt == len_q - len_t'(1));
  assign drain_last = (drain_cnt == DW'(PIPE_LAT));
  assign res_take   = res_valid_q & bus.res_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and operand-stage control
  always_comb begin
    nxt    = state;
    op_ctl = OP_HOLD;
    case (state)
      IDLE:   if (bus.start) nxt = CLEAR;
      CLEAR:  nxt = (len_q == '0) ? DRAIN : STREAM;
      STREAM: begin
        if (accept)    op_ctl = OP_LOAD;
        if (last_beat) nxt = DRAIN;
      end
      DRAIN: begin
        op_ctl = OP_ZERO;
        if (drain_last) nxt = HOLD;
      end
      HOLD:   if (res_take) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Job length latch and beat/drain counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && bus.start) len_q <= bus.len;
      if (state == CLEAR)             beat_cnt <= '0;
      else if (accept)                beat_cnt <= beat_cnt + len_t'(1);
      if (state == DRAIN)             drain_cnt <= drain_cnt + DW'(1);
      else                            drain_cnt <= '0;
    end
  end

  // Capture the array outputs on the first HOLD cycle; release on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_acc_q   <= '0;
      res_ai_q    <= '0;
    end else if (state == HOLD && !res_valid_q) begin
      res_valid_q <= 1'b1;
      res_acc_q   <= bus.acc_in;
      res_ai_q    <= bus.ai_in;
    end else if (res_take) begin
      res_valid_q <= 1'b0;
    end
  end

  vmg_operand_stage u_ops (
    .clk    (clk),
    .rst    (rst),
    .ctl    (op_ctl),
    .feat_d (bus.features_in),
    .wgt_d  (bus.weights_in),
    .feat_q (bus.mult_features),
    .wgt_q  (bus.mult_weights),
    .ce     (bus.mult_ce)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.mult_clr  = (state == CLEAR);
  assign bus.res_valid = res_valid_q;
  assign bus.res_acc   = res_acc_q;
  assign bus.res_ai    = res_ai_q;
  assign bus.done      = res_take;

endmodule

// File: tb/tb_vmg_job_sequencer.sv
// Scoreboard bench for vmg_job_sequencer with a behavioural multiplier array
// (acc = sum of feature*weight, ai = sum of weights, PL-cycle pipeline).
module tb_vmg_job_sequencer;
  import vmg_pkg::*;

  localparam int PL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmg_job_sequencer_if bus ();

  vmg_job_sequencer #(.PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    lane_acc_t acc;
    lane_acc_t ai;
    string     name;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic operand_t fill(input int v);
    operand_t r;
    for (int l = 0; l < Q; l++)
      for (int e = 0; e < NP; e++) r[l][e] = REG_DEPTH'(v);
    return r;
  endfunction

  function automatic lane_acc_t lacc(input int a0, input int a1, input int a2, input int a3);
    lane_acc_t r;
    r[0] = ACC_W'(a0); r[1] = ACC_W'(a1); r[2] = ACC_W'(a2); r[3] = ACC_W'(a3);
    return r;
  endfunction

  // ---------------- behavioural multiplier array ----------------
  function automatic lane_acc_t dotp(input operand_t f, input operand_t w);
    lane_acc_t r = '0;
    for (int l = 0; l < Q; l++)
      for (int e = 0; e < NP; e++) r[l] = r[l] + ACC_W'(f[l][e]) * ACC_W'(w[l][e]);
    return r;
  endfunction

  function automatic lane_acc_t wsum(input operand_t w);
    lane_acc_t r = '0;
    for (int l = 0; l < Q; l++)
      for (int e = 0; e < NP; e++) r[l] = r[l] + ACC_W'(w[l][e]);
    return r;
  endfunction

  lane_acc_t pp [PL];
  lane_acc_t pw [PL];
  logic      pv [PL];
  lane_acc_t acc_m, ai_m;

  always @(posedge clk or posedge rst) begin
    if (rst || bus.mult_clr) begin
      acc_m <= '0;
      ai_m  <= '0;
      for (int i = 0; i < PL; i++) begin
        pv[i] <= 1'b0; pp[i] <= '0; pw[i] <= '0;
      end
    end else begin
      if (pv[PL-1])
        for (int l = 0; l < Q; l++) begin
          acc_m[l] <= acc_m[l] + pp[PL-1][l];
          ai_m[l]  <= ai_m[l] + pw[PL-1][l];
        end
      for (int i = PL-1; i > 0; i--) begin
        pv[i] <= pv[i-1]; pp[i] <= pp[i-1]; pw[i] <= pw[i-1];
      end
      pv[0] <= bus.mult_ce;
      pp[0] <= dotp(bus.mult_features, bus.mult_weights);
      pw[0] <= wsum(bus.mult_weights);
    end
  end

  assign bus.acc_in = acc_m;
  assign bus.ai_in  = ai_m;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      checks++;
      if (bus.mult_ce && bus.mult_clr) begin
        errors++;
        $display("FAIL ce_clr_overlap: got ce=1 clr=1 want not both");
      end
      chk("done_vs_handshake", 128'(bus.done), 128'(bus.res_valid && bus.res_ready));
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got acc %0h want none", bus.res_acc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_acc"}, bus.res_acc, e.acc);
          chk({e.name, "_ai"},  bus.res_ai,  e.ai);
        end
      end
    end
  end

  // ---------------- job driver ----------------
  task automatic run_job(input string name, input int n, input operand_t f, input operand_t w,
                         input bit gap, input int hold_lo, input lane_acc_t eacc,
                         input lane_acc_t eai, input int elat, input int ece);
    int beats = 0, lat = -1, ce_n = 0, clr_n = 0, held = 0;
    bit fin = 0, rdy_bad = 0, stab_bad = 0, busy_ok = 0;
    lane_acc_t snap = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = len_t'(n);
    sb.push_back('{eacc, eai, name});
    @(posedge clk);
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mult_ce)  ce_n++;
      if (bus.mult_clr) clr_n++;
      if (n == 0 && bus.in_ready) rdy_bad = 1;
      bus.in_valid    = (beats < n) && (!gap || k[0]);
      bus.features_in = bus.in_valid ? f : '0;
      bus.weights_in  = bus.in_valid ? w : '0;
      if (bus.in_valid && bus.in_ready) beats++;
      if (bus.res_valid) begin
        if (lat < 0) begin
          lat  = k;
          snap = bus.res_acc;
        end
        if (held < hold_lo) begin
          if (bus.res_acc !== snap) stab_bad = 1;
          bus.res_ready = 1'b0;
          bus.start     = 1'b1;
          held++;
        end else begin
          bus.res_ready = 1'b1;
          bus.start     = (hold_lo > 0);
        end
      end else if (lat >= 0) begin
        fin           = 1;
        busy_ok       = !bus.busy;
        bus.res_ready = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no result want result", name);
    end
    if (elat >= 0) chk({name, "_latency"}, 128'(lat), 128'(elat));
    chk({name, "_ce_count"},  128'(ce_n),  128'(ece));
    chk({name, "_clr_count"}, 128'(clr_n), 128'(1));
    chk({name, "_beats"},     128'(beats), 128'(n));
    chk({name, "_idle_after"}, 128'(busy_ok), 128'(1));
    if (n == 0)      chk({name, "_no_in_ready"}, 128'(rdy_bad), 128'(0));
    if (hold_lo > 0) chk({name, "_hold_stable"}, 128'(stab_bad), 128'(0));
    chk({name, "_sb_drained"}, 128'(sb.size()), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    operand_t lanef;
    int b;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.len         = '0;
    bus.in_valid    = 1'b0;
    bus.features_in = '0;
    bus.weights_in  = '0;
    bus.res_ready   = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",      128'(bus.busy),      128'(0));
    chk("rst_in_ready",  128'(bus.in_ready),  128'(0));
    chk("rst_mult_clr",  128'(bus.mult_clr),  128'(0));
    chk("rst_mult_ce",   128'(bus.mult_ce),   128'(0));
    chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
    chk("rst_done",      128'(bus.done),      128'(0));
    chk("rst_res_acc",   bus.res_acc,         128'(0));
    chk("rst_mult_feat", 128'(bus.mult_features), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // len=3 of all-ones: 3 beats * 4 elements = 12 per lane
    run_job("ones3", 3, fill(1), fill(1), 0, 0, lacc(12,12,12,12), lacc(12,12,12,12),
            1+3+1+PL+1, 3+PL+1);
    // same with in_valid on alternating cycles
    run_job("ones3_gap", 3, fill(1), fill(1), 1, 0, lacc(12,12,12,12), lacc(12,12,12,12),
            -1, 3+PL+1);
    // len=0: clear then drain only
    run_job("len0", 0, fill(7), fill(7), 0, 0, lacc(0,0,0,0), lacc(0,0,0,0),
            1+0+1+PL+1, PL+1);
    // ready held low for 10 cycles with start pulses
    run_job("hold10", 1, fill(1), fill(1), 0, 10, lacc(4,4,4,4), lacc(4,4,4,4),
            1+1+1+PL+1, 1+PL+1);
    // back-to-back: features 2 / weights 1 over 2 beats, then features 3 over 1 beat
    run_job("b2b_a", 2, fill(2), fill(1), 0, 0, lacc(16,16,16,16), lacc(8,8,8,8),
            1+2+1+PL+1, 2+PL+1);
    run_job("b2b_b", 1, fill(3), fill(1), 0, 0, lacc(12,12,12,12), lacc(4,4,4,4),
            1+1+1+PL+1, 1+PL+1);
    // lane-distinct features (lane+1), weights 5, 2 beats: 40*(lane+1)
    for (int l = 0; l < Q; l++)
      for (int e = 0; e < NP; e++) lanef[l][e] = REG_DEPTH'(l + 1);
    run_job("lanes", 2, lanef, fill(5), 0, 0, lacc(40,80,120,160), lacc(40,40,40,40),
            1+2+1+PL+1, 2+PL+1);

    // reset in the middle of a 5-beat job after 2 beats
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = len_t'(5);
    @(posedge clk);
    b = 0;
    for (int k = 0; k < 20 && b < 2; k++) begin
      @(negedge clk);
      bus.start       = 1'b0;
      bus.in_valid    = 1'b1;
      bus.features_in = fill(1);
      bus.weights_in  = fill(1);
      if (bus.in_ready) b++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_pre_ce",   128'(bus.mult_ce), 128'(1));
    chk("mid_pre_busy", 128'(bus.busy),    128'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy",      128'(bus.busy),      128'(0));
    chk("mid_rst_res_valid", 128'(bus.res_valid), 128'(0));
    chk("mid_rst_ce",        128'(bus.mult_ce),   128'(0));
    chk("mid_rst_clr",       128'(bus.mult_clr),  128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_job("post_rst", 1, fill(1), fill(1), 0, 0, lacc(4,4,4,4), lacc(4,4,4,4),
            1+1+1+PL+1, 1+PL+1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
